// File: rtl/mips_cpu_bus_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mips_cpu_bus_mem_ctrl_if
//  Brief    : Avalon-MM memory bus bundle between the CPU sequencer and memory.
//  Revision : 1.0  initial release
// ============================================================================
interface mips_cpu_bus_mem_ctrl_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_bus_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_cpu_bus_mem_ctrl
//  Brief    : Bus-master sequencer: instruction fetch, load/store, exec strobes.
//  Revision : 1.0  initial release
// ============================================================================
module mips_cpu_bus_mem_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [3:0]  BE_FETCH     = 4'hF
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [31:0]        pc,
    input  wire logic               active,
    input  wire logic               mem_read,
    input  wire logic               mem_write,
    input  wire logic [31:0]        data_addr,
    input  wire logic [31:0]        data_wdata,
    input  wire logic [3:0]         data_be,
    mips_cpu_bus_mem_ctrl_if.master bus,
    output logic [31:0]             instr,
    output logic [31:0]             load_data,
    output logic                    exec1,
    output logic                    exec2,
    output logic                    halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC1  = 3'd2,
        S_MEM    = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] load_data_q, load_data_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        exec2_q, exec2_d;
    logic        halted_q, halted_d;

    logic [31:0] w_address;
    logic        w_read;
    logic        w_write;
    logic [31:0] w_writedata;
    logic [3:0]  w_byteenable;
    logic        w_exec1;
    logic        w_unused;

    // Word alignment discards the low address bits; the reset vector is documentary.
    assign w_unused = ^{pc[1:0], data_addr[1:0], RESET_VECTOR};

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        load_data_d  = load_data_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        w_address    = '0;
        w_read       = 1'b0;
        w_write      = 1'b0;
        w_writedata  = '0;
        w_byteenable = '0;
        w_exec1      = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (!active) begin
                    state_d = S_HALTED;
                end else begin
                    w_read       = 1'b1;
                    w_address    = {pc[31:2], 2'b00};
                    w_byteenable = BE_FETCH;
                    if (!bus.waitrequest) begin
                        instr_d = bus.readdata;
                        state_d = S_EXEC1;
                    end
                end
            end
            S_EXEC1: begin
                w_exec1 = 1'b1;
                rd_d    = mem_read;
                // A simultaneous write request is dropped in favour of the read.
                wr_d    = mem_write & ~mem_read;
                addr_d  = data_addr[31:2];
                wdata_d = data_wdata;
                be_d    = data_be;
                state_d = (mem_read || mem_write) ? S_MEM : S_EXEC2;
            end
            S_MEM: begin
                w_address    = {addr_q, 2'b00};
                w_byteenable = be_q;
                if (rd_q) begin
                    w_read = 1'b1;
                end else if (wr_q) begin
                    w_write     = 1'b1;
                    w_writedata = wdata_q;
                end
                if (!bus.waitrequest) begin
                    if (rd_q) begin
                        load_data_d = bus.readdata;
                    end
                    state_d = S_EXEC2;
                end
            end
            S_EXEC2:  state_d = S_FETCH;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase

        // Strobes are taken from flops so the PC unit sees clean edges.
        exec2_d  = (state_d == S_EXEC2);
        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            load_data_q <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            exec2_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            load_data_q <= load_data_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            exec2_q     <= exec2_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.address    = w_address;
    assign bus.read       = w_read;
    assign bus.write      = w_write;
    assign bus.writedata  = w_writedata;
    assign bus.byteenable = w_byteenable;
    assign instr          = instr_q;
    assign load_data      = load_data_q;
    assign exec1          = w_exec1;
    assign exec2          = exec2_q;
    assign halted         = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_bus_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_cpu_bus_mem_ctrl
//  Brief    : Directed and randomized bench for the bus-master sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_cpu_bus_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        active;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_be;
    logic [31:0] instr;
    logic [31:0] load_data;
    logic        exec1;
    logic        exec2;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural expectations: last fetched word and last loaded word.
    logic [31:0] exp_instr;
    logic [31:0] exp_load;

    mips_cpu_bus_mem_ctrl_if bus_if ();

    mips_cpu_bus_mem_ctrl #(
        .RESET_VECTOR (32'hBFC00000),
        .BE_FETCH     (4'hF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .active     (active),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_be    (data_be),
        .bus        (bus_if.master),
        .instr      (instr),
        .load_data  (load_data),
        .exec1      (exec1),
        .exec2      (exec2),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete instruction starting in the first FETCH cycle; the bench
    // plays memory and checks every bus cycle against the expected sequence.
    task automatic run_instr(input logic [31:0] ipc, input logic [31:0] iword, input int fw,
                             input logic rd, input logic wr, input logic [31:0] da,
                             input logic [31:0] dw, input logic [3:0] dbe, input int mw,
                             input logic [31:0] ldword);
        logic st;
        st     = wr && !rd;
        pc     = ipc;
        active = 1'b1;
        for (int i = 0; i <= fw; i++) begin
            bus_if.waitrequest = (i < fw);
            bus_if.readdata    = (i < fw) ? $urandom : iword;
            @(negedge clk);
            chk("fetch_read",  32'(bus_if.read), 32'd1);
            chk("fetch_write", 32'(bus_if.write), 32'd0);
            chk("fetch_addr",  bus_if.address, {ipc[31:2], 2'b00});
            chk("fetch_be",    32'(bus_if.byteenable), 32'hF);
            chk("fetch_exec1", 32'(exec1), 32'd0);
            chk("fetch_exec2", 32'(exec2), 32'd0);
            chk("fetch_instr_hold", instr, exp_instr);
            tick();
        end
        exp_instr          = iword;
        bus_if.waitrequest = 1'($urandom);
        bus_if.readdata    = $urandom;
        mem_read   = rd;
        mem_write  = wr;
        data_addr  = da;
        data_wdata = dw;
        data_be    = dbe;
        @(negedge clk);
        chk("exec1_pulse", 32'(exec1), 32'd1);
        chk("exec1_instr", instr, exp_instr);
        chk("exec1_read",  32'(bus_if.read), 32'd0);
        chk("exec1_write", 32'(bus_if.write), 32'd0);
        chk("exec1_exec2", 32'(exec2), 32'd0);
        tick();
        mem_read   = 1'($urandom);
        mem_write  = 1'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
        data_be    = 4'($urandom);
        if (rd || wr) begin
            for (int j = 0; j <= mw; j++) begin
                bus_if.waitrequest = (j < mw);
                bus_if.readdata    = (j < mw) ? $urandom : ldword;
                @(negedge clk);
                chk("mem_addr",  bus_if.address, {da[31:2], 2'b00});
                chk("mem_be",    32'(bus_if.byteenable), 32'(dbe));
                chk("mem_read",  32'(bus_if.read), 32'(rd));
                chk("mem_write", 32'(bus_if.write), 32'(st));
                if (st) chk("mem_wdata", bus_if.writedata, dw);
                chk("mem_exec1", 32'(exec1), 32'd0);
                chk("mem_exec2", 32'(exec2), 32'd0);
                chk("mem_load_hold", load_data, exp_load);
                tick();
            end
            if (rd) exp_load = ldword;
        end
        bus_if.waitrequest = 1'($urandom);
        bus_if.readdata    = $urandom;
        @(negedge clk);
        chk("exec2_pulse", 32'(exec2), 32'd1);
        chk("exec2_exec1", 32'(exec1), 32'd0);
        chk("exec2_read",  32'(bus_if.read), 32'd0);
        chk("exec2_write", 32'(bus_if.write), 32'd0);
        chk("exec2_load",  load_data, exp_load);
        chk("exec2_instr", instr, exp_instr);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        pc = 32'hBFC00000;
        active = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        data_addr = '0;
        data_wdata = '0;
        data_be = '0;
        bus_if.waitrequest = 1'b0;
        bus_if.readdata = '0;
        exp_instr = '0;
        exp_load = '0;
        tick();
        tick();

        @(negedge clk);
        chk("rst_read",   32'(bus_if.read), 32'd0);
        chk("rst_write",  32'(bus_if.write), 32'd0);
        chk("rst_addr",   bus_if.address, 32'd0);
        chk("rst_instr",  instr, 32'd0);
        chk("rst_load",   load_data, 32'd0);
        chk("rst_exec1",  32'(exec1), 32'd0);
        chk("rst_exec2",  32'(exec2), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("idle_read", 32'(bus_if.read), 32'd0);
        tick();

        // Zero-wait fetch, fetch with three wait states, load, store.
        run_instr(32'hBFC00000, 32'h24020005, 0, 1'b0, 1'b0, '0, '0, '0, 0, '0);
        run_instr(32'hBFC00004, 32'h8C430006, 3, 1'b0, 1'b0, '0, '0, '0, 0, '0);
        run_instr(32'hBFC00008, 32'h8C221006, 0, 1'b1, 1'b0, 32'h00001006, 32'h0, 4'b1100, 1, 32'hDEADBEEF);
        run_instr(32'hBFC0000C, 32'hAC221000, 0, 1'b0, 1'b1, 32'h00002003, 32'h12345678, 4'hF, 0, '0);
        // Read and write together: read wins.
        run_instr(32'hBFC00010, 32'h00000000, 1, 1'b1, 1'b1, 32'h00000ABC, 32'hCAFEF00D, 4'h3, 2, 32'h0BADC0DE);

        for (int k = 0; k < 40; k++) begin
            run_instr($urandom, $urandom, $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                      $urandom, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom);
        end

        // Reset while a store is stalled in MEM.
        pc = 32'h00400000;
        bus_if.waitrequest = 1'b0;
        bus_if.readdata = 32'hAC000000;
        tick();
        mem_read = 1'b0;
        mem_write = 1'b1;
        data_addr = 32'h00003000;
        data_wdata = 32'h55AA55AA;
        data_be = 4'hF;
        tick();
        bus_if.waitrequest = 1'b1;
        @(negedge clk);
        chk("midmem_write", 32'(bus_if.write), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_write = 1'b0;
        exp_instr = '0;
        exp_load = '0;
        @(negedge clk);
        chk("midrst_read",  32'(bus_if.read), 32'd0);
        chk("midrst_write", 32'(bus_if.write), 32'd0);
        chk("midrst_instr", instr, 32'd0);
        chk("midrst_load",  load_data, 32'd0);
        chk("midrst_exec2", 32'(exec2), 32'd0);
        tick();
        bus_if.waitrequest = 1'b0;
        run_instr(32'hBFC00000, 32'h3C1DBFC0, 0, 1'b1, 1'b0, 32'h00000010, '0, 4'hF, 0, 32'h11223344);

        // Halt: inactive at fetch entry.
        pc = 32'h00000000;
        active = 1'b0;
        @(negedge clk);
        chk("halt_entry_read",   32'(bus_if.read), 32'd0);
        chk("halt_entry_halted", 32'(halted), 32'd0);
        tick();
        active = 1'b1;
        for (int h = 0; h < 20; h++) begin
            @(negedge clk);
            chk("halted_flag",  32'(halted), 32'd1);
            chk("halted_read",  32'(bus_if.read), 32'd0);
            chk("halted_write", 32'(bus_if.write), 32'd0);
            chk("halted_exec",  32'({exec1, exec2}), 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
